fetch_unit: RTL and testbench

- Instruction-supply side of the CU interface for the PIC16C57 core.
- Owns the 11-bit program counter (PC), the 2-level hardware stack and the instruction register (IR). IR drives CU.instIn.
- Steps on the CU fetch phase. All PC, stack and IR updates happen only in Q4, so the next instruction is fetched while the current one executes.
- Resolves GOTO, CALL, RETLW, computed PCL writes and skips by flushing the prefetched word to a NOP. This gives two-cycle branches.

---
 rtl/fetch_unit.sv | 93 +++++++++
 tb/tb_fetch_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-supply side of the PIC16C57 core: program counter, two-level
// return stack and instruction register, all advanced only on the Q4 edge.
module fetch_unit #(
   parameter int                  PC_WIDTH     = 11,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = 11'h7FF,
   parameter logic [11:0]         NOP_WORD     = 12'h000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          qPhase,
   input  logic                halt,
   input  logic [11:0]         pmData,
   input  logic [1:0]          pa,
   input  logic                skipReq,
   input  logic                pclWrite,
   input  logic [7:0]          pclData,
   output logic [PC_WIDTH-1:0] pmAddr,
   output logic [11:0]         instOut,
   output logic [7:0]          pclOut,
   output logic [PC_WIDTH-1:0] stackTop
);

   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [PC_WIDTH-1:0] stack1_q, stack1_d;
   logic [PC_WIDTH-1:0] stack2_q, stack2_d;
   logic [11:0]         ir_q, ir_d;

   logic                is_goto, is_call, is_retlw, q4_step;
   logic [PC_WIDTH-1:0] pc_inc, goto_tgt, call_tgt, pcl_tgt;

   // Decode looks at the word executing now, not at the word being fetched.
   assign is_goto  = (ir_q[11:9] == 3'b101);
   assign is_call  = (ir_q[11:8] == 4'b1001);
   assign is_retlw = (ir_q[11:8] == 4'b1000);
   assign q4_step  = (qPhase == 2'd3) && !halt;

   assign pc_inc   = pc_q + PC_WIDTH'(1);
   assign goto_tgt = PC_WIDTH'({pa, ir_q[8:0]});
   assign call_tgt = PC_WIDTH'({pa, 1'b0, ir_q[7:0]});
   assign pcl_tgt  = PC_WIDTH'({pa, 1'b0, pclData});

   always_comb begin
      pc_d     = pc_q;
      ir_d     = ir_q;
      stack1_d = stack1_q;
      stack2_d = stack2_q;
      if (q4_step) begin
         // Any control transfer discards the prefetched word, giving a two-cycle branch.
         if (is_goto) begin
            pc_d = goto_tgt;
            ir_d = NOP_WORD;
         end else if (is_call) begin
            stack2_d = stack1_q;
            stack1_d = pc_q;
            pc_d     = call_tgt;
            ir_d     = NOP_WORD;
         end else if (is_retlw) begin
            pc_d     = stack1_q;
            stack1_d = stack2_q;
            ir_d     = NOP_WORD;
         end else if (pclWrite) begin
            pc_d = pcl_tgt;
            ir_d = NOP_WORD;
         end else if (skipReq) begin
            pc_d = pc_inc;
            ir_d = NOP_WORD;
         end else begin
            pc_d = pc_inc;
            ir_d = pmData;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q     <= RESET_VECTOR;
         ir_q     <= NOP_WORD;
         stack1_q <= '0;
         stack2_q <= '0;
      end else begin
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         stack1_q <= stack1_d;
         stack2_q <= stack2_d;
      end
   end

   assign pmAddr   = pc_q;
   assign instOut  = ir_q;
   assign pclOut   = pc_q[7:0];
   assign stackTop = stack1_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a program image in a local ROM, one table
// row per instruction cycle, plus hand sequences for phase/halt/reset hazards.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  q_phase;
   logic        halt;
   logic [11:0] pm_data;
   logic [1:0]  pa;
   logic        skip_req;
   logic        pcl_write;
   logic [7:0]  pcl_data;
   logic [10:0] pm_addr;
   logic [11:0] inst_out;
   logic [7:0]  pcl_out;
   logic [10:0] stack_top;

   logic [11:0] rom [0:2047];

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic        skp;
      logic        pclw;
      logic [7:0]  pcld;
      logic [1:0]  pa;
      logic [10:0] e_pc;
      logic [11:0] e_ir;
      logic [10:0] e_stk;
   } vec_t;

   vec_t vecs [26];

   fetch_unit dut (
      .clk      (clk),
      .rst      (rst),
      .qPhase   (q_phase),
      .halt     (halt),
      .pmData   (pm_data),
      .pa       (pa),
      .skipReq  (skip_req),
      .pclWrite (pcl_write),
      .pclData  (pcl_data),
      .pmAddr   (pm_addr),
      .instOut  (inst_out),
      .pclOut   (pcl_out),
      .stackTop (stack_top)
   );

   always #5 clk = ~clk;

   assign pm_data = rom[pm_addr];

   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %03h expected %03h", name, act, exp);
   endtask

   task automatic chk_all(input string tag, input logic [10:0] e_pc, input logic [11:0] e_ir,
                          input logic [10:0] e_stk);
      chk({tag, " pc"},    {1'b0, pm_addr},   {1'b0, e_pc});
      chk({tag, " ir"},    inst_out,          e_ir);
      chk({tag, " pcl"},   {4'h0, pcl_out},   {4'h0, e_pc[7:0]});
      chk({tag, " stack"}, {1'b0, stack_top}, {1'b0, e_stk});
   endtask

   task automatic edge_at(input logic [1:0] ph);
      q_phase = ph;
      @(posedge clk);
      #1;
   endtask

   task automatic instr_cycle();
      for (int p = 0; p < 4; p++) edge_at(2'(p));
   endtask

   initial begin
      for (int a = 0; a < 2048; a++) rom[a] = {1'b0, 11'(a)};
      rom[11'h000] = 12'hAA5;   // GOTO 0x0A5
      rom[11'h2A6] = 12'hB23;   // GOTO 0x123
      rom[11'h123] = 12'h940;   // CALL 0x40
      rom[11'h040] = 12'h950;   // CALL 0x50
      rom[11'h050] = 12'h960;   // CALL 0x60
      rom[11'h060] = 12'h811;   // RETLW
      rom[11'h051] = 12'h812;   // RETLW
      rom[11'h041] = 12'h813;   // RETLW
      rom[11'h042] = 12'hA10;   // GOTO 0x010
      rom[11'h483] = 12'h970;   // CALL 0x70

      //            skp   pclw  pcld   pa     pc       ir        stack
      vecs[0]  = '{1'b0, 1'b0, 8'h00, 2'd0, 11'h000, 12'h7FF, 11'h000};
      vecs[1]  = '{1'b0, 1'b0, 8'h00, 2'd0, 11'h001, 12'hAA5, 11'h000};
      vecs[2]  = '{1'b0, 1'b0, 8'h00, 2'd1, 11'h2A5, 12'h000, 11'h000};
      vecs[3]  = '{1'b0, 1'b0, 8'h00, 2'd1, 11'h2A6, 12'h2A5, 11'h000};
      vecs[4]  = '{1'b0, 1'b0, 8'h00, 2'd0, 11'h2A7, 12'hB23, 11'h000};
      vecs[5]  = '{1'b0, 1'b0, 8'h00, 2'd0, 11'h123, 12'h000, 11'h000};
      vecs[6]  = '{1'b0, 1'b0, 8'h00, 2'd0, 11'h124, 12'h940, 11'h000};
      vecs[7]  = '{1'b0, 1'b0, 8'h00, 2'd0, 11'h040, 12'h000, 11'h124};
      vecs[8]  = '{1'b0, 1'b0, 8'h00, 2'd0, 11'h041, 12'h950, 11'h124};
      vecs[9]  = '{1'b0, 1'b0, 8'h00, 2'd0, 11'h050, 12'h000, 11'h041};
      vecs[10] = '{1'b0, 1'b0, 8'h00, 2'd0, 11'h051, 12'h960, 11'h041};
      vecs[11] = '{1'b0, 1'b0, 8'h00, 2'd0, 11'h060, 12'h000, 11'h051};
      vecs[12] = '{1'b0, 1'b0, 8'h00, 2'd0, 11'h061, 12'h811, 11'h051};
      vecs[13] = '{1'b0, 1'b0, 8'h00, 2'd0, 11'h051, 12'h000, 11'h041};
      vecs[14] = '{1'b0, 1'b0, 8'h00, 2'd0, 11'h052, 12'h812, 11'h041};
      vecs[15] = '{1'b0, 1'b0, 8'h00, 2'd0, 11'h041, 12'h000, 11'h041};
      vecs[16] = '{1'b0, 1'b0, 8'h00, 2'd0, 11'h042, 12'h813, 11'h041};
      vecs[17] = '{1'b0, 1'b0, 8'h00, 2'd0, 11'h041, 12'h000, 11'h041};
      vecs[18] = '{1'b1, 1'b0, 8'h00, 2'd0, 11'h042, 12'h000, 11'h041};
      vecs[19] = '{1'b0, 1'b0, 8'h00, 2'd0, 11'h043, 12'hA10, 11'h041};
      vecs[20] = '{1'b1, 1'b1, 8'h33, 2'd0, 11'h010, 12'h000, 11'h041};
      vecs[21] = '{1'b1, 1'b0, 8'h00, 2'd0, 11'h011, 12'h000, 11'h041};
      vecs[22] = '{1'b0, 1'b0, 8'h00, 2'd0, 11'h012, 12'h011, 11'h041};
      vecs[23] = '{1'b1, 1'b1, 8'h80, 2'd2, 11'h480, 12'h000, 11'h041};
      vecs[24] = '{1'b0, 1'b0, 8'h00, 2'd2, 11'h481, 12'h480, 11'h041};
      vecs[25] = '{1'b0, 1'b0, 8'h00, 2'd2, 11'h482, 12'h481, 11'h041};

      rst = 1'b1; q_phase = 2'd0; halt = 1'b0; pa = 2'd0;
      skip_req = 1'b0; pcl_write = 1'b0; pcl_data = 8'h00;
      edge_at(2'd0);
      edge_at(2'd3);
      rst = 1'b0;
      chk_all("reset", 11'h7FF, 12'h000, 11'h000);

      foreach (vecs[i]) begin
         skip_req  = vecs[i].skp;
         pcl_write = vecs[i].pclw;
         pcl_data  = vecs[i].pcld;
         pa        = vecs[i].pa;
         instr_cycle();
         chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_ir, vecs[i].e_stk);
      end

      // Only Q4 may update, even with strobes asserted in Q1..Q3.
      skip_req = 1'b1; pcl_write = 1'b1; pcl_data = 8'h55; pa = 2'd0;
      for (int p = 0; p < 3; p++) begin
         edge_at(2'(p));
         chk_all($sformatf("hold_q%0d", p + 1), 11'h482, 12'h481, 11'h041);
      end
      skip_req = 1'b0; pcl_write = 1'b0;

      halt = 1'b1;
      edge_at(2'd3);
      chk_all("halt_q4", 11'h482, 12'h481, 11'h041);
      halt = 1'b0;
      instr_cycle();
      chk_all("resume", 11'h483, 12'h482, 11'h041);
      instr_cycle();
      chk_all("fetch_call", 11'h484, 12'h970, 11'h041);
      instr_cycle();
      chk_all("call2", 11'h070, 12'h000, 11'h484);

      edge_at(2'd0);
      rst = 1'b1;
      edge_at(2'd1);
      chk_all("rst_q2", 11'h7FF, 12'h000, 11'h000);
      rst = 1'b0;
      edge_at(2'd2);
      edge_at(2'd3);
      chk_all("post_rst", 11'h000, 12'h7FF, 11'h000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
